// File: rtl/sha_pkg.sv
// Shared types and job-layout constants for the SHA mining front end.
package sha_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        SOLVE,
        REPORT
    } loader_state_t;

    localparam int JOB_WORDS  = 24;
    localparam int MID_WORDS  = 8;
    localparam int HEAD_WORDS = 16;
    localparam int MID_BITS   = MID_WORDS * 32;
    localparam int HEAD_BITS  = HEAD_WORDS * 32;

endpackage

// File: rtl/sha_solve_timer.sv
// Counts SOLVE cycles and pulses when the job has run out of nonce space.
module sha_solve_timer #(
    parameter int                 LIMIT_W     = 40,
    parameter logic [LIMIT_W-1:0] SOLVE_LIMIT = 40'd137438953472
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    logic [LIMIT_W-1:0] r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + LIMIT_W'(1);
        end
    end

    assign o_terminal = i_enable && (r_count == (SOLVE_LIMIT - LIMIT_W'(1)));

endmodule

// File: rtl/sha_work_loader.sv
// Job loader for sha_block: assembles the 24-word job, runs the solve window
// and hands back one found/exhausted/aborted result per job.
module sha_work_loader
    import sha_pkg::*;
#(
    parameter int                 LIMIT_W     = 40,
    parameter logic [LIMIT_W-1:0] SOLVE_LIMIT = 40'd137438953472
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [31:0]          word_in,
    input  logic                 word_valid,
    output logic                 word_ready,
    input  logic                 abort,
    input  logic                 flag,
    input  logic [31:0]          goldenNonce,
    output logic [MID_BITS-1:0]  midState,
    output logic [HEAD_BITS-1:0] headData,
    output logic                 loadState,
    output logic                 solveEn,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 result_found,
    output logic [31:0]          result_nonce,
    output logic                 busy
);

    loader_state_t        r_state;
    loader_state_t        w_nextState;
    logic [4:0]           r_wordCnt;
    logic                 r_started;
    logic [MID_BITS-1:0]  r_midState;
    logic [HEAD_BITS-1:0] r_headData;
    logic                 r_loadState;
    logic                 r_solveEn;
    logic                 r_resultValid;
    logic                 r_resultFound;
    logic [31:0]          r_resultNonce;

    logic                 w_terminal;
    logic                 w_accept;
    logic                 w_lastWord;
    logic [4:0]           w_wordIdx;
    logic [2:0]           w_midSlot;
    logic [3:0]           w_headSlot;

    sha_solve_timer #(
        .LIMIT_W     (LIMIT_W),
        .SOLVE_LIMIT (SOLVE_LIMIT)
    ) u_timer (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_clear    (r_state != SOLVE),
        .i_enable   (r_state == SOLVE),
        .o_terminal (w_terminal)
    );

    // r_started keeps word_ready low while in reset and for the first cycle after it.
    assign word_ready = r_started && ((r_state == IDLE) || (r_state == LOAD));
    assign w_accept   = word_valid && word_ready && !(abort && (r_state == LOAD));
    assign w_lastWord = (r_wordCnt == 5'(JOB_WORDS - 1));
    assign w_wordIdx  = (r_state == IDLE) ? 5'd0 : r_wordCnt;
    assign w_midSlot  = 3'(MID_WORDS - 1) - w_wordIdx[2:0];
    assign w_headSlot = 4'(HEAD_WORDS - 1) - (w_wordIdx[3:0] - 4'd8);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= IDLE;
            r_started <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_started <= 1'b1;
        end
    end

    // Priority inside SOLVE: abort, then flag, then terminal count.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = LOAD;
            LOAD: begin
                if (abort)                      w_nextState = IDLE;
                else if (w_accept && w_lastWord) w_nextState = ARM;
            end
            ARM:     w_nextState = abort ? REPORT : SOLVE;
            SOLVE:   if (abort || flag || w_terminal) w_nextState = REPORT;
            REPORT:  if (result_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wordCnt <= '0;
        end else if ((r_state == LOAD) && abort) begin
            r_wordCnt <= '0;
        end else if (w_accept) begin
            r_wordCnt <= (r_state == LOAD && w_lastWord) ? 5'd0 : w_wordIdx + 5'd1;
        end
    end

    // Word k lands MSW-first: words 0-7 fill midState, 8-23 fill headData.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_midState <= '0;
            r_headData <= '0;
        end else if (w_accept) begin
            if (w_wordIdx < 5'(MID_WORDS)) begin
                r_midState[{w_midSlot, 5'b0} +: 32] <= word_in;
            end else begin
                r_headData[{w_headSlot, 5'b0} +: 32] <= word_in;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_loadState   <= 1'b0;
            r_solveEn     <= 1'b0;
            r_resultValid <= 1'b0;
        end else begin
            r_loadState   <= (w_nextState == ARM) || (w_nextState == SOLVE);
            r_solveEn     <= (w_nextState == SOLVE);
            r_resultValid <= (w_nextState == REPORT);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_resultFound <= 1'b0;
            r_resultNonce <= '0;
        end else if (((r_state == ARM) || (r_state == SOLVE)) && abort) begin
            r_resultFound <= 1'b0;
            r_resultNonce <= '0;
        end else if (r_state == SOLVE) begin
            if (flag) begin
                r_resultFound <= 1'b1;
                r_resultNonce <= goldenNonce;
            end else if (w_terminal) begin
                r_resultFound <= 1'b0;
                r_resultNonce <= '0;
            end
        end
    end

    assign midState     = r_midState;
    assign headData     = r_headData;
    assign loadState    = r_loadState;
    assign solveEn      = r_solveEn;
    assign result_valid = r_resultValid;
    assign result_found = r_resultFound;
    assign result_nonce = r_resultNonce;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_sha_work_loader.sv
// Scoreboard bench for sha_work_loader with a short solve window (16 cycles).
module tb_sha_work_loader;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [31:0]  word_in;
    logic         word_valid;
    logic         word_ready;
    logic         abort;
    logic         flag;
    logic [31:0]  goldenNonce;
    logic [255:0] midState;
    logic [511:0] headData;
    logic         loadState;
    logic         solveEn;
    logic         result_valid;
    logic         result_ready;
    logic         result_found;
    logic [31:0]  result_nonce;
    logic         busy;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] expQ[$];

    always #5 clk = ~clk;

    sha_work_loader #(
        .LIMIT_W     (40),
        .SOLVE_LIMIT (40'd16)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .word_in      (word_in),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .abort        (abort),
        .flag         (flag),
        .goldenNonce  (goldenNonce),
        .midState     (midState),
        .headData     (headData),
        .loadState    (loadState),
        .solveEn      (solveEn),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_found (result_found),
        .result_nonce (result_nonce),
        .busy         (busy)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Streams a full job of base+0 .. base+23; returns at the negedge where the loader sits in ARM.
    task automatic applyStimulus(input logic [31:0] base, input bit gapped);
        int gap;
        int guard;
        for (int k = 0; k < 24; k++) begin
            if (gapped) begin
                gap = $urandom_range(0, 2);
                word_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            word_in    = base + 32'(k);
            word_valid = 1'b1;
            guard = 0;
            while (!word_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 20) checkOutput("word_ready timeout", 0, 1);
            @(negedge clk);
        end
        word_valid = 1'b0;
    endtask

    task automatic collectResult();
        int          guard;
        logic [32:0] exp;
        guard = 0;
        while (!result_valid && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (!result_valid) begin
            checkOutput("result timeout", 0, 1);
            return;
        end
        if (expQ.size() == 0) begin
            checkOutput("unexpected result", 1, 0);
        end else begin
            exp = expQ.pop_front();
            checkOutput("result_found", 64'(result_found), 64'(exp[32]));
            checkOutput("result_nonce", 64'(result_nonce), 64'(exp[31:0]));
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        checkOutput("result_valid drop", 64'(result_valid), 0);
        checkOutput("busy after report", 64'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_rst = 1'b0; word_in = '0; word_valid = 1'b0; abort = 1'b0;
        flag = 1'b0; goldenNonce = '0; result_ready = 1'b0;

        #12;
        checkOutput("rst word_ready", 64'(word_ready), 0);
        checkOutput("rst busy", 64'(busy), 0);
        checkOutput("rst loadState", 64'(loadState), 0);
        checkOutput("rst solveEn", 64'(solveEn), 0);
        checkOutput("rst result_valid", 64'(result_valid), 0);
        checkOutput("rst result_nonce", 64'(result_nonce), 0);
        checkOutput("rst midState", 64'(|midState), 0);
        checkOutput("rst headData", 64'(|headData), 0);
        @(negedge clk);
        n_rst = 1'b1;

        // Back-to-back job, with a stale flag during ARM that must be ignored.
        applyStimulus(32'h1, 1'b0);
        checkOutput("mid word0", 64'(midState[255:224]), 64'h1);
        checkOutput("mid word7", 64'(midState[31:0]), 64'h8);
        checkOutput("head word8", 64'(headData[511:480]), 64'h9);
        checkOutput("head word23", 64'(headData[31:0]), 64'h18);
        checkOutput("arm loadState", 64'(loadState), 1);
        checkOutput("arm solveEn", 64'(solveEn), 0);
        checkOutput("arm word_ready", 64'(word_ready), 0);
        flag = 1'b1; goldenNonce = 32'hBAD0BAD0;
        @(negedge clk);
        flag = 1'b0;
        checkOutput("solve loadState", 64'(loadState), 1);
        checkOutput("solve solveEn", 64'(solveEn), 1);
        checkOutput("arm flag ignored", 64'(result_valid), 0);

        // Found nonce, held under back-pressure.
        flag = 1'b1; goldenNonce = 32'hDEADBEEF;
        expQ.push_back({1'b1, 32'hDEADBEEF});
        @(negedge clk);
        flag = 1'b0; goldenNonce = 32'h0;
        checkOutput("found valid next cycle", 64'(result_valid), 1);
        checkOutput("found solveEn off", 64'(solveEn), 0);
        checkOutput("found loadState off", 64'(loadState), 0);
        repeat (5) begin
            @(negedge clk);
            checkOutput("held valid", 64'(result_valid), 1);
            checkOutput("held nonce", 64'(result_nonce), 64'hDEADBEEF);
        end
        collectResult();

        // Exhaustion after exactly 16 SOLVE cycles.
        applyStimulus(32'h200, 1'b0);
        @(negedge clk);
        repeat (15) @(negedge clk);
        checkOutput("limit-1 still solving", 64'(solveEn), 1);
        checkOutput("limit-1 no result", 64'(result_valid), 0);
        expQ.push_back({1'b1 ^ 1'b1, 32'h0});
        @(negedge clk);
        checkOutput("limit result valid", 64'(result_valid), 1);
        collectResult();

        // Abort a partial job after 10 words, then load a fresh one.
        for (int k = 0; k < 10; k++) begin
            word_in = 32'h900 + 32'(k); word_valid = 1'b1;
            @(negedge clk);
        end
        word_valid = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort load busy", 64'(busy), 0);
        checkOutput("abort load ready", 64'(word_ready), 1);
        repeat (3) @(negedge clk);
        checkOutput("abort load no result", 64'(result_valid), 0);
        applyStimulus(32'h100, 1'b0);
        checkOutput("reload mid word0", 64'(midState[255:224]), 64'h100);
        checkOutput("reload mid word3", 64'(midState[159:128]), 64'h103);
        checkOutput("reload head word23", 64'(headData[31:0]), 64'h117);
        @(negedge clk);
        flag = 1'b1; goldenNonce = 32'h12345678;
        expQ.push_back({1'b1, 32'h12345678});
        @(negedge clk);
        flag = 1'b0;
        collectResult();

        // Abort beats flag.
        applyStimulus(32'h300, 1'b0);
        @(negedge clk);
        flag = 1'b1; abort = 1'b1; goldenNonce = 32'h55AA55AA;
        expQ.push_back({1'b0, 32'h0});
        @(negedge clk);
        flag = 1'b0; abort = 1'b0;
        collectResult();

        // Flag beats terminal count.
        applyStimulus(32'h400, 1'b0);
        @(negedge clk);
        repeat (15) @(negedge clk);
        flag = 1'b1; goldenNonce = 32'hCAFEF00D;
        expQ.push_back({1'b1, 32'hCAFEF00D});
        @(negedge clk);
        flag = 1'b0;
        collectResult();

        // Gapped stream, then asynchronous reset in the middle of SOLVE.
        applyStimulus(32'h500, 1'b1);
        checkOutput("gapped head word23", 64'(headData[31:0]), 64'h517);
        @(negedge clk);
        repeat (3) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        checkOutput("async loadState", 64'(loadState), 0);
        checkOutput("async solveEn", 64'(solveEn), 0);
        checkOutput("async busy", 64'(busy), 0);
        checkOutput("async word_ready", 64'(word_ready), 0);
        checkOutput("async midState", 64'(|midState), 0);
        checkOutput("async headData", 64'(|headData), 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        checkOutput("post reset ready", 64'(word_ready), 1);

        checkOutput("scoreboard empty", 64'(expQ.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
